// File: rtl/icache_responder.sv
// icache_responder
//   Direct-mapped instruction cache sitting between the fetch port and the
//   memory/bus adapter. Each line holds one 64-bit doubleword.
//   - Hits are answered combinationally; the line data is registered onto
//     ioMem_rData at the hit edge.
//   - Misses issue one refill request on the mem_req_* port, wait for
//     mem_resp_valid, then pulse ioMem_rvalid for one cycle.
//   - The write inputs are accepted but have no effect on any state.
//
// Ports
//   clock, reset              system clock, synchronous active-high reset
//   ioMem_ren/addr            fetch request (sampled only in IDLE)
//   ioMem_wen/wMask/wData     write request (ignored)
//   ioMem_hit                 combinational hit indication
//   ioMem_rvalid/rData        registered miss-data pulse / response data
//   flush                     invalidate every line (fence.i)
//   mem_req_valid/ready/addr  refill request handshake
//   mem_resp_valid/data       refill data return
//   hit_cnt, miss_cnt         wrapping performance counters
module icache_responder #(
    parameter int ADDR_W     = 32,
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ioMem_ren,
    input  logic [ADDR_W-1:0] ioMem_addr,
    input  logic              ioMem_wen,
    input  logic [7:0]        ioMem_wMask,
    input  logic [63:0]       ioMem_wData,
    output logic              ioMem_hit,
    output logic              ioMem_rvalid,
    output logic [63:0]       ioMem_rData,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [63:0]       mem_resp_data,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - 3 - INDEX_BITS;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_REQ  = 3'b010,
        S_WAIT = 3'b100
    } state_t;

    state_t              state_q, state_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]    tag_arr_q  [LINES];
    logic [TAG_W-1:0]    tag_arr_d  [LINES];
    logic [63:0]         data_arr_q [LINES];
    logic [63:0]         data_arr_d [LINES];
    logic [ADDR_W-1:0]   miss_addr_q, miss_addr_d;
    // Set when a flush lands while a refill is outstanding; the returning
    // data is still delivered but must not be installed as a valid line.
    logic                flushed_q, flushed_d;
    logic [63:0]         rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

    logic [INDEX_BITS-1:0] req_idx, miss_idx;
    logic [TAG_W-1:0]      req_tag, miss_tag;
    logic                  hit;

    assign req_idx  = ioMem_addr[3+INDEX_BITS-1:3];
    assign req_tag  = ioMem_addr[ADDR_W-1:3+INDEX_BITS];
    assign miss_idx = miss_addr_q[3+INDEX_BITS-1:3];
    assign miss_tag = miss_addr_q[ADDR_W-1:3+INDEX_BITS];

    // Flush suppresses a hit in the same cycle so the request falls into the miss path.
    assign hit = (state_q == S_IDLE) && ioMem_ren && valid_q[req_idx]
               && (tag_arr_q[req_idx] == req_tag) && !flush;

    // Write port and the always-zero offset bits carry no information.
    logic unused_ok;
    assign unused_ok = ^{ioMem_wen, ioMem_wMask, ioMem_wData, ioMem_addr[2:0]};

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        tag_arr_d   = tag_arr_q;
        data_arr_d  = data_arr_q;
        miss_addr_d = miss_addr_q;
        flushed_d   = flushed_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (hit) begin
                    rdata_d   = data_arr_q[req_idx];
                    hit_cnt_d = hit_cnt_q + CNT_W'(1);
                end else if (ioMem_ren) begin
                    miss_addr_d = ioMem_addr;
                    miss_cnt_d  = miss_cnt_q + CNT_W'(1);
                    flushed_d   = 1'b0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    rdata_d  = mem_resp_data;
                    rvalid_d = 1'b1;
                    if (!flushed_q && !flush) begin
                        valid_d[miss_idx]    = 1'b1;
                        tag_arr_d[miss_idx]  = miss_tag;
                        data_arr_d[miss_idx] = mem_resp_data;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush overrides any install decided above.
        if (flush) begin
            valid_d = '0;
            if (state_q != S_IDLE) flushed_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            miss_addr_q <= '0;
            flushed_q   <= 1'b0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            miss_addr_q <= miss_addr_d;
            flushed_q   <= flushed_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Line storage is never reset; the valid bits gate its use.
    always_ff @(posedge clock) begin
        tag_arr_q  <= tag_arr_d;
        data_arr_q <= data_arr_d;
    end

    assign ioMem_hit     = hit;
    assign ioMem_rvalid  = rvalid_q;
    assign ioMem_rData   = rdata_q;
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_addr  = miss_addr_q;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;

endmodule
